// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: default widths, accumulator sizing and
// the switch bit indices also used by the AXI register block.
package fir_pkg;

  localparam int FIR_DATA_WIDTH_DEF = 32;
  localparam int MAX_LOG2_DEF       = 8;
  localparam int FIFO_DEPTH_DEF     = 4;
  localparam int DROP_CNT_WIDTH_DEF = 16;

  typedef enum int {
    SWITCH_FIR_EN   = 0,
    SWITCH_DECIM_EN = 1
  } fir_switch_e;

  // One extra bit beyond the block-sum growth keeps the rounding bias in range.
  function automatic int acc_width(input int data_w, input int max_log2);
    return data_w + max_log2 + 1;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// Head reads as zero while empty; a push when full is accepted only alongside a pop.
module fir_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
    level    = level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals the slot being vacated.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fir_decim.sv
// Boxcar decimator: averages 2^k accepted samples and queues results in a FWFT FIFO.
// Define FIR_DECIM_ROUND_EN to round half up instead of flooring the block average.
module fir_decim
  import fir_pkg::*;
#(
  parameter int FIR_DATA_WIDTH = FIR_DATA_WIDTH_DEF,
  parameter int MAX_LOG2       = MAX_LOG2_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF,
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
  input  logic                             fir_clk,
  input  logic                             fir_aresetn,
  input  logic signed [FIR_DATA_WIDTH-1:0] fir_in,
  input  logic                             in_valid,
  input  logic                             decim_en,
  input  logic        [3:0]                ratio_log2,
  output logic signed [FIR_DATA_WIDTH-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
  output logic [DROP_CNT_WIDTH-1:0]        drop_cnt
);

  localparam int ACC_W = acc_width(FIR_DATA_WIDTH, MAX_LOG2);
  localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic signed [ACC_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] v,
    input logic        [3:0]       k
  );
`ifdef FIR_DECIM_ROUND_EN
    logic signed [ACC_W-1:0] bias;
    bias = (k == 4'd0) ? '0 : (ACC_W'(1) << (k - 4'd1));
    return (v + bias) >>> k;
`else
    return v >>> k;
`endif
  endfunction

  logic signed [ACC_W-1:0]          acc_q, acc_d, acc_base, sum;
  logic        [CNT_W-1:0]          cnt_q, cnt_d, cnt_base, cnt_last;
  logic        [3:0]                ratio_prev_q, k;
  logic signed [FIR_DATA_WIDTH-1:0] res_reg_q, res_reg_d;
  logic                             res_pend_q, res_pend_d;
  logic        [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                             accept, last, ratio_chg;
  logic                             fifo_empty, fifo_full, pop, drop;
  logic        [LVL_W-1:0]          level;
  logic        [FIR_DATA_WIDTH-1:0] head;

  // Stage 1: accumulate a block; the edge that completes it loads res_reg.
  always_comb begin
    k          = (ratio_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : ratio_log2;
    ratio_chg  = (ratio_log2 != ratio_prev_q);
    acc_base   = ratio_chg ? '0 : acc_q;
    cnt_base   = ratio_chg ? '0 : cnt_q;
    sum        = acc_base + {{(ACC_W-FIR_DATA_WIDTH){fir_in[FIR_DATA_WIDTH-1]}}, fir_in};
    cnt_last   = CNT_W'((32'd1 << k) - 32'd1);
    accept     = decim_en && in_valid;
    last       = accept && (cnt_base == cnt_last);
    res_reg_d  = FIR_DATA_WIDTH'(round_shift(sum, k));
    acc_d      = acc_base;
    cnt_d      = cnt_base;
    res_pend_d = 1'b0;
    if (!decim_en) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (last) begin
      acc_d      = '0;
      cnt_d      = '0;
      res_pend_d = 1'b1;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_base + CNT_W'(1);
    end
  end

  // Stage 2: push the pending result; a full FIFO without a pop drops it.
  always_comb begin
    out_valid  = !fifo_empty;
    pop        = out_valid && out_ready;
    drop       = res_pend_q && fifo_full && !pop;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_CNT_WIDTH'(1) : drop_cnt_q;
    out_data   = head;
    fifo_level = level;
    drop_cnt   = drop_cnt_q;
  end

  always_ff @(posedge fir_clk) begin
    if (!fir_aresetn) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      res_pend_q   <= 1'b0;
      ratio_prev_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_pend_q   <= res_pend_d;
      ratio_prev_q <= ratio_log2;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_ff @(posedge fir_clk) begin
    if (last) res_reg_q <= res_reg_d;
  end

  fir_sync_fifo #(
    .WIDTH (FIR_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (fir_clk),
    .rst_n     (fir_aresetn),
    .push      (res_pend_q),
    .push_data (res_reg_q),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench for fir_decim: directed scenarios plus a randomized run
// compared against a block-average reference model.
module tb_fir_decim;

  logic               fir_clk = 1'b0;
  logic               fir_aresetn;
  logic signed [31:0] fir_in;
  logic               in_valid;
  logic               decim_en;
  logic        [3:0]  ratio_log2;
  logic signed [31:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic        [2:0]  fifo_level;
  logic        [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic               collect = 1'b0;
  logic signed [31:0] got_q[$];

  fir_decim dut (
    .fir_clk     (fir_clk),
    .fir_aresetn (fir_aresetn),
    .fir_in      (fir_in),
    .in_valid    (in_valid),
    .decim_en    (decim_en),
    .ratio_log2  (ratio_log2),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
  );

  always #5 fir_clk = ~fir_clk;

  always @(negedge fir_clk) begin
    if (collect && out_valid && out_ready) got_q.push_back(out_data);
  end

  // Average of one block as the arithmetic rule states it.
  function automatic logic signed [31:0] ref_avg(input longint sum, input int k);
    longint r;
`ifdef FIR_DECIM_ROUND_EN
    if (k > 0) sum = sum + (longint'(1) << (k - 1));
`endif
    r = sum >>> k;
    return r[31:0];
  endfunction

  task automatic step();
    @(posedge fir_clk);
    #1;
  endtask

  task automatic feed(input logic signed [31:0] d);
    in_valid = 1'b1;
    fir_in   = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [3:0] k);
    fir_aresetn = 1'b0;
    in_valid    = 1'b0;
    fir_in      = '0;
    decim_en    = 1'b1;
    out_ready   = 1'b0;
    ratio_log2  = k;
    step();
    step();
    fir_aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(4'd2);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%0d want=0", out_valid); end
    n_checks++; if (out_data !== 32'sd0) begin n_errors++; $display("FAIL reset_data got=%0d want=0", out_data); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
  endtask

  task automatic test_mean_k2();
    logic signed [31:0] exp;
    do_reset(4'd2);
    exp = ref_avg(longint'(1 + 2 + 3 + 4), 2);
    feed(1); feed(2); feed(3);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL k2_early_valid got=%0d want=0", out_valid); end
    feed(4);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL k2_latency1 got=%0d want=0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL k2_latency2 got=%0d want=1", out_valid); end
    n_checks++; if (out_data !== exp) begin n_errors++; $display("FAIL k2_data got=%0d want=%0d", out_data, exp); end
    // Data must hold while the consumer stalls.
    step();
    n_checks++; if (out_data !== exp) begin n_errors++; $display("FAIL k2_stall got=%0d want=%0d", out_data, exp); end
  endtask

  task automatic test_negative();
    logic signed [31:0] exp;
    do_reset(4'd2);
    exp = ref_avg(longint'(-7), 2);
    feed(-1); feed(-2); feed(-2); feed(-2);
    step();
    n_checks++; if (out_data !== exp) begin n_errors++; $display("FAIL neg_data got=%0d want=%0d", out_data, exp); end
    n_checks++; if (exp !== -32'sd2) begin n_errors++; $display("FAIL neg_model got=%0d want=-2", exp); end
  endtask

  task automatic test_max_k8();
    longint             s;
    logic signed [31:0] exp;
    do_reset(4'd8);
    s = 0;
    for (int i = 0; i < 256; i++) begin
      feed(32'sh7FFFFFFF);
      s += longint'(32'sh7FFFFFFF);
    end
    exp = ref_avg(s, 8);
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL k8_valid got=%0d want=1", out_valid); end
    n_checks++; if (out_data !== exp) begin n_errors++; $display("FAIL k8_data got=%h want=%h", out_data, exp); end
    // Exponent above the maximum clamps to 8.
    do_reset(4'd15);
    for (int i = 0; i < 255; i++) feed(4);
    step();
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL clamp_early got=%0d want=0", fifo_level); end
    feed(4);
    step();
    n_checks++; if (fifo_level !== 3'd1) begin n_errors++; $display("FAIL clamp_level got=%0d want=1", fifo_level); end
    n_checks++; if (out_data !== 32'sd4) begin n_errors++; $display("FAIL clamp_data got=%0d want=4", out_data); end
  endtask

  task automatic test_overflow();
    do_reset(4'd0);
    for (int i = 10; i <= 15; i++) feed(i);
    step();
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL ovf_level got=%0d want=4", fifo_level); end
    n_checks++; if (drop_cnt !== 16'd2) begin n_errors++; $display("FAIL ovf_drop got=%0d want=2", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 10; i <= 13; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ovf_drain_valid got=%0d want=1", out_valid); end
      n_checks++; if (out_data !== 32'(i)) begin n_errors++; $display("FAIL ovf_drain_data got=%0d want=%0d", out_data, i); end
      step();
    end
    out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL ovf_empty_level got=%0d want=0", fifo_level); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_empty_valid got=%0d want=0", out_valid); end
    n_checks++; if (out_data !== 32'sd0) begin n_errors++; $display("FAIL ovf_empty_data got=%0d want=0", out_data); end
  endtask

  task automatic test_ratio_change();
    do_reset(4'd3);
    for (int i = 0; i < 5; i++) feed(100 + i);
    ratio_log2 = 4'd1;
    feed(7);
    feed(9);
    step();
    n_checks++; if (fifo_level !== 3'd1) begin n_errors++; $display("FAIL rchg_level got=%0d want=1", fifo_level); end
    n_checks++; if (out_data !== ref_avg(longint'(16), 1)) begin n_errors++; $display("FAIL rchg_data got=%0d want=8", out_data); end
    feed(50);
    fir_aresetn = 1'b0;
    in_valid    = 1'b1;
    fir_in      = 32'sd60;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mrst_valid got=%0d want=0", out_valid); end
    n_checks++; if (out_data !== 32'sd0) begin n_errors++; $display("FAIL mrst_data got=%0d want=0", out_data); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL mrst_level got=%0d want=0", fifo_level); end
    fir_aresetn = 1'b1;
    feed(20);
    feed(22);
    step();
    n_checks++; if (out_data !== ref_avg(longint'(42), 1)) begin n_errors++; $display("FAIL mrst_fresh got=%0d want=21", out_data); end
  endtask

  task automatic test_full_push_pop();
    do_reset(4'd0);
    for (int i = 0; i < 5; i++) feed(200 + i);
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL fpp_full got=%0d want=4", fifo_level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_errors++; $display("FAIL fpp_level got=%0d want=4", fifo_level); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL fpp_drop got=%0d want=0", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (out_data !== 32'(200 + i)) begin n_errors++; $display("FAIL fpp_order got=%0d want=%0d", out_data, 200 + i); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int                 k;
    longint             part_sum;
    int                 part_n;
    logic signed [31:0] exp_q[$];
    logic signed [31:0] d;
    logic               en, v;
    k = int'($urandom_range(1, 3));
    do_reset(4'(k));
    got_q.delete();
    part_sum = 0;
    part_n   = 0;
    collect  = 1'b1;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      v  = $urandom_range(0, 1);
      d  = $urandom;
      decim_en  = en;
      in_valid  = v;
      fir_in    = d;
      out_ready = (c % 2 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!en) begin
        part_sum = 0;
        part_n   = 0;
      end else if (v) begin
        part_sum += longint'(d);
        part_n++;
        if (part_n == (1 << k)) begin
          exp_q.push_back(ref_avg(part_sum, k));
          part_sum = 0;
          part_n   = 0;
        end
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) step();
    collect = 1'b0;
    n_checks++; if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rnd_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rnd_data[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL rnd_drop got=%0d want=0", drop_cnt); end
    n_checks++; if (fifo_level !== 3'd0) begin n_errors++; $display("FAIL rnd_level got=%0d want=0", fifo_level); end
    out_ready = 1'b0;
  endtask

  initial begin
    fir_aresetn = 1'b0;
    in_valid    = 1'b0;
    fir_in      = '0;
    decim_en    = 1'b1;
    ratio_log2  = 4'd0;
    out_ready   = 1'b0;
    test_reset();
    test_mean_k2();
    test_negative();
    test_max_k8();
    test_overflow();
    test_ratio_change();
    test_full_push_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
